// File: rtl/fir_requant_buffer.sv
// Requantizes the firfilter accumulator stream (decimate, round, shift, saturate) into a
// small first-word-fall-through FIFO. Optional saturation counter: FIR_REQUANT_SATCNT_EN.
module fir_requant_buffer #(
  parameter int IN_WIDTH   = 38,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [IN_WIDTH-1:0]  i_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_sat,
  output logic                 o_overflow
`ifdef FIR_REQUANT_SATCNT_EN
  ,
  output logic [15:0]          o_sat_count
`endif
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  // 2^(SHIFT-1), or zero when no shift is applied.
  localparam logic signed [IN_WIDTH:0] RND = ({{IN_WIDTH{1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SAT_MIN =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Decimation: keep the sample seen while the counter is zero.
  logic [CW-1:0] dec_cnt;
  logic          keep;

  assign keep = i_valid && (dec_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (i_valid) begin
      dec_cnt <= (dec_cnt == CW'(DECIM-1)) ? '0 : dec_cnt + CW'(1);
    end
  end

  // Stage 1: sign-extend one bit so the rounding add cannot wrap, then shift.
  logic signed [IN_WIDTH:0] ext;
  logic signed [IN_WIDTH:0] rounded;
  logic signed [IN_WIDTH:0] s1_data;
  logic                     v1;

  assign ext     = {i_data[IN_WIDTH-1], i_data};
  assign rounded = ext + RND;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      s1_data <= '0;
    end else begin
      v1 <= keep;
      if (keep) s1_data <= rounded >>> SHIFT;
    end
  end

  // Stage 2: clamp to the signed output range.
  logic                 clamp_hi;
  logic                 clamp_lo;
  logic [OUT_WIDTH-1:0] sat_val;
  logic [OUT_WIDTH-1:0] s2_data;
  logic                 v2;

  assign clamp_hi = s1_data > SAT_MAX;
  assign clamp_lo = s1_data < SAT_MIN;
  assign sat_val  = clamp_hi ? OUT_MAX : (clamp_lo ? OUT_MIN : s1_data[OUT_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      v2      <= 1'b0;
      s2_data <= '0;
      o_sat   <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) s2_data <= sat_val;
      if (v1 && (clamp_hi || clamp_lo)) o_sat <= 1'b1;
    end
  end

`ifdef FIR_REQUANT_SATCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      o_sat_count <= '0;
    end else if (v1 && (clamp_hi || clamp_lo) && (o_sat_count != 16'hFFFF)) begin
      o_sat_count <= o_sat_count + 16'd1;
    end
  end
`endif

  // Output handshake: a word transfers on a rising edge where o_valid && o_ready; o_valid
  // and o_data depend only on registered state and hold steady until that transfer.
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 full;
  logic                 rd;
  logic                 wr;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign rd      = o_valid && o_ready;
  assign wr      = v2 && (!full || rd);
  assign o_valid = (count != '0);
  assign o_data  = o_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s2_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !rd)      count <= count + (AW+1)'(1);
      else if (rd && !wr) count <= count - (AW+1)'(1);
      if (v2 && full && !rd) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_requant_buffer.sv
// Randomized and directed bench for fir_requant_buffer with a queue-based reference model
// and a negedge monitor; a second instance with DECIM=4 covers decimation.
module tb_fir_requant_buffer;

  localparam int IW    = 38;
  localparam int OW    = 16;
  localparam int SH    = 15;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0;
  logic [IW-1:0] i_data = '0;
  logic          o_ready = 1'b0;
  logic          o_valid;
  logic [OW-1:0] o_data;
  logic          o_sat;
  logic          o_overflow;
  logic          o_ready4 = 1'b1;
  logic          o_valid4;
  logic [OW-1:0] o_data4;
  logic          o_sat4;
  logic          o_overflow4;
`ifdef FIR_REQUANT_SATCNT_EN
  logic [15:0]   o_sat_count;
  logic [15:0]   o_sat_count4;
`endif

  always #5 clk = ~clk;

  fir_requant_buffer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DECIM(1),
                       .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_sat(o_sat), .o_overflow(o_overflow)
`ifdef FIR_REQUANT_SATCNT_EN
    , .o_sat_count(o_sat_count)
`endif
  );

  fir_requant_buffer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DECIM(4),
                       .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid4), .o_ready(o_ready4), .o_data(o_data4),
    .o_sat(o_sat4), .o_overflow(o_overflow4)
`ifdef FIR_REQUANT_SATCNT_EN
    , .o_sat_count(o_sat_count4)
`endif
  );

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int pops4 = 0;
  int sat4_seen = 0;
  logic checking = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: round half up, floor-shift, clamp. Returns {saturated, word}.
  function automatic logic [OW:0] requant(input logic [IW-1:0] x);
    logic signed [IW-1:0] xs;
    longint t;
    xs = x;
    t = longint'(xs);
    t = (t + (longint'(1) << (SH-1))) >>> SH;
    if (t > 32767)  return {1'b1, 16'h7FFF};
    if (t < -32768) return {1'b1, 16'h8000};
    return {1'b0, t[15:0]};
  endfunction

  function automatic logic [IW-1:0] rand_data();
    logic [63:0] r;
    logic signed [IW-1:0] v;
    r = {$urandom, $urandom};
    v = r[IW-1:0];
    v = v >>> $urandom_range(0, IW-1);
    return v;
  endfunction

  // Reference model: kept samples spend two edges in flight, then enter a FIFO of DEPTH
  // words that drops arrivals only when full and not being read on the same edge.
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_q4[$];
  logic          d0_v = 1'b0, d1_v = 1'b0;
  logic [OW:0]   d0_r = '0, d1_r = '0;
  logic [OW:0]   rq;
  int            mcount = 0;
  int            dec4 = 0;
  int            exp_satcnt = 0;
  logic          exp_sat = 1'b0, exp_ovf = 1'b0;
  logic          rd_m, wr_m;

  always @(posedge clk) begin
    if (reset) begin
      d0_v = 1'b0; d1_v = 1'b0; mcount = 0; dec4 = 0;
      exp_sat = 1'b0; exp_ovf = 1'b0; exp_satcnt = 0;
      exp_q.delete(); exp_q4.delete();
    end else begin
      rd_m = (mcount != 0) && o_ready;
      wr_m = 1'b0;
      if (d1_v) begin
        if (mcount < DEPTH || rd_m) begin
          wr_m = 1'b1;
          exp_q.push_back(d1_r[OW-1:0]);
        end else begin
          exp_ovf = 1'b1;
        end
      end
      mcount = mcount + int'(wr_m) - int'(rd_m);
      if (d0_v && d0_r[OW]) begin
        exp_sat = 1'b1;
        if (exp_satcnt < 65535) exp_satcnt++;
      end
      d1_v = d0_v; d1_r = d0_r;
      d0_v = i_valid; d0_r = requant(i_data);
      if (i_valid) begin
        if (dec4 == 0) begin
          rq = requant(i_data);
          exp_q4.push_back(rq[OW-1:0]);
        end
        dec4 = (dec4 + 1) % 4;
      end
    end
  end

  // Monitor: compares flags every cycle and pops the scoreboard on each handshake.
  logic [OW-1:0] e;
  always @(negedge clk) begin
    if (o_sat4) sat4_seen++;
    if (checking) begin
      check("o_valid", longint'(o_valid), longint'(mcount != 0));
      check("o_sat", longint'(o_sat), longint'(exp_sat));
      check("o_overflow", longint'(o_overflow), longint'(exp_ovf));
      check("o_overflow4", longint'(o_overflow4), 0);
`ifdef FIR_REQUANT_SATCNT_EN
      check("o_sat_count", longint'(o_sat_count), longint'(exp_satcnt));
`endif
      if (o_valid && o_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("pop_unexpected", longint'(o_data), -1);
        end else begin
          e = exp_q.pop_front();
          check("o_data", longint'(o_data), longint'(e));
        end
      end
      if (o_valid4 && o_ready4) begin
        pops4++;
        if (exp_q4.size() == 0) begin
          check("pop4_unexpected", longint'(o_data4), -1);
        end else begin
          e = exp_q4.pop_front();
          check("o_data4", longint'(o_data4), longint'(e));
        end
      end
    end
  end

  // Driver: called at posedge+1, holds the inputs across the next rising edge.
  task automatic drive(input logic v, input logic [IW-1:0] d, input logic rdy);
    i_valid = v;
    i_data  = d;
    o_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [IW-1:0] scaled(input int k);
    return IW'(longint'(k) << SH);
  endfunction

  logic [IW-1:0] rnd_vec[4];

  initial begin
    rnd_vec[0] = 38'd16384;
    rnd_vec[1] = -38'sd16384;
    rnd_vec[2] = 38'd49151;
    rnd_vec[3] = 38'd49152;

    do_reset(2);
    checking = 1'b1;
    check("reset_o_data", longint'(o_data), 0);
    check("reset_o_valid", longint'(o_valid), 0);

    // Rounding boundaries, isolated by idle gaps.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rnd_vec[i], 1'b1);
      repeat ($urandom_range(3, 5)) drive(1'b0, '0, 1'b1);
    end

    // Saturation at both rails.
    drive(1'b1, 38'sd2147483648, 1'b1);
    drive(1'b1, -38'sd2147483648, 1'b1);
    repeat (5) drive(1'b0, '0, 1'b1);
    check("sat_after_rails", longint'(o_sat), 1);
`ifdef FIR_REQUANT_SATCNT_EN
    check("sat_count_rails", longint'(o_sat_count), 2);
`endif

    // Overflow with the consumer stalled, then drain.
    do_reset(1);
    pops = 0;
    for (int k = 1; k <= 20; k++) drive(1'b1, scaled(k), 1'b0);
    repeat (4) drive(1'b0, '0, 1'b0);
    check("overflow_set", longint'(o_overflow), 1);
    repeat (20) drive(1'b0, '0, 1'b1);
    check("overflow_drain_count", longint'(pops), 16);

    // Full FIFO with continuous reads: nothing may drop.
    do_reset(1);
    pops = 0;
    for (int k = 0; k < 16; k++) drive(1'b1, scaled(k + 100), 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0);
    for (int k = 0; k < 50; k++) drive(1'b1, scaled(k + 200), 1'b1);
    repeat (20) drive(1'b0, '0, 1'b1);
    check("full_rw_count", longint'(pops), 66);
    check("full_rw_no_overflow", longint'(o_overflow), 0);

    // Decimation by 4 on the second instance.
    do_reset(1);
    pops4 = 0;
    for (int k = 0; k < 12; k++) drive(1'b1, scaled(k), 1'b1);
    repeat (8) drive(1'b0, '0, 1'b1);
    check("decim_count", longint'(pops4), 3);

    // Reset with 5 words buffered and 2 in flight.
    for (int k = 0; k < 7; k++)
      drive(1'b1, (k == 3) ? 38'sd2147483648 : scaled(k + 1), 1'b0);
    do_reset(1);
    check("midreset_o_valid", longint'(o_valid), 0);
    check("midreset_o_sat", longint'(o_sat), 0);
    check("midreset_o_overflow", longint'(o_overflow), 0);
    pops = 0;
    drive(1'b1, scaled(77), 1'b1);
    repeat (5) drive(1'b0, '0, 1'b1);
    check("midreset_first_count", longint'(pops), 1);

    // Random traffic with bursty backpressure.
    for (int c = 0; c < 2000; c++)
      drive($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 9) > 3);
    repeat (40) drive(1'b0, '0, 1'b1);
    check("final_queue_empty", longint'(exp_q.size()), 0);
    check("final_queue4_empty", longint'(exp_q4.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
